// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and one-cycle MTHI/MTLO
module muldiv_unit #(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           oper,
  input  logic [DATA_BITS-1:0] opa,
  input  logic [DATA_BITS-1:0] opb,
  input  logic                 cancel,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic [DATA_BITS-1:0] hi,
  output logic [DATA_BITS-1:0] lo
);
  localparam int N = DATA_BITS;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;
  state_t state;
  logic [1:0] op;
  logic [N-1:0] xa, xb, am, bm, dif;
  logic [2*N-1:0] p, mstep, dstep;
  logic [N:0] msum;
  logic [CW-1:0] cnt;
  logic neg_x, neg_a, dz, is_sgn, ge;
  assign busy = state != IDLE;
  assign is_sgn = !op[0];
  assign am = (is_sgn && xa[N-1]) ? -xa : xa;
  assign bm = (is_sgn && xb[N-1]) ? -xb : xb;
  assign msum = {1'b0, p[2*N-1:N]} + (p[0] ? {1'b0, xa} : '0);
  assign mstep = {msum, p[N-1:1]};
  // p holds {remainder, dividend bits still to consume / quotient bits produced}
  assign ge = p[2*N-1:N-1] >= {1'b0, xb};
  assign dif = p[2*N-2:N-1] - xb;
  assign dstep = ge ? {dif, p[N-2:0], 1'b1} : {p[2*N-2:0], 1'b0};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      op <= '0;
      xa <= '0;
      xb <= '0;
      p <= '0;
      cnt <= '0;
      neg_x <= 1'b0;
      neg_a <= 1'b0;
      dz <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      div_zero <= 1'b0;
      if (cancel && state != IDLE) state <= IDLE;
      else case (state)
        IDLE: if (start && !cancel) begin
          if (!oper[2]) begin
            op <= oper[1:0];
            xa <= opa;
            xb <= opb;
            state <= PREP;
          end else if (oper[1:0] == 2'd0) hi <= opa;
          else if (oper[1:0] == 2'd1) lo <= opa;
        end
        PREP: begin
          xa <= am;
          xb <= bm;
          p <= {{N{1'b0}}, op[1] ? am : bm};
          cnt <= CW'(N);
          neg_x <= is_sgn && (xa[N-1] ^ xb[N-1]);
          neg_a <= is_sgn && xa[N-1];
          dz <= op[1] && xb == '0;
          state <= (op[1] && xb == '0) ? FIX : CALC;
        end
        CALC: begin
          p <= op[1] ? dstep : mstep;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          done <= 1'b1;
          div_zero <= dz;
          if (!dz && op[1]) begin
            lo <= neg_x ? -p[N-1:0] : p[N-1:0];
            hi <= neg_a ? -p[2*N-1:N] : p[2*N-1:N];
          end else if (!dz) {hi, lo} <= neg_x ? -p : p;
        end
      endcase
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic clk = 1'b0, rst, start, cancel, busy, done, div_zero;
  logic [2:0] oper;
  logic [31:0] opa, opb, hi, lo, mhi, mlo;
  logic mdz;
  int n_cmp = 0, n_err = 0;
  muldiv_unit #(.DATA_BITS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .oper(oper), .opa(opa), .opb(opb),
    .cancel(cancel), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] pr;
    sa = $signed(a);
    sb = $signed(b);
    mdz = 1'b0;
    case (op)
      3'd0: begin pr = sa * sb; {mhi, mlo} = pr; end
      3'd1: begin pr = {32'b0, a} * {32'b0, b}; {mhi, mlo} = pr; end
      3'd2: if (b == 0) mdz = 1'b1;
        else begin pr = sa / sb; mlo = pr[31:0]; pr = sa % sb; mhi = pr[31:0]; end
      3'd3: if (b == 0) mdz = 1'b1;
        else begin mlo = a / b; mhi = a % b; end
      3'd4: mhi = a;
      3'd5: mlo = a;
      default: ;
    endcase
  endfunction
  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    oper = op;
    opa = a;
    opb = b;
    @(negedge clk);
    start = 1'b0;
    oper = 3'($urandom_range(0, 7));
    opa = $urandom;
    opb = $urandom;
  endtask
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit b2b);
    int lat = 0;
    model(op, a, b);
    issue(op, a, b);
    if (op < 3'd4) begin
      chk("busy", busy, 1);
      for (int i = 1; i <= 60; i++) begin
        @(negedge clk);
        if (done) begin lat = i; break; end
      end
      chk("latency", lat, mdz ? 2 : 34);
      chk("div_zero", div_zero, mdz);
      chk("busy_done", busy, 0);
      chk("hi", hi, mhi);
      chk("lo", lo, mlo);
      if (!b2b) begin
        @(negedge clk);
        chk("pulse", {busy, done, div_zero}, 0);
      end
    end else begin
      chk("busy_mt", busy, 0);
      chk("hi_mt", hi, mhi);
      chk("lo_mt", lo, mlo);
    end
  endtask
  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; oper = '0; opa = '0; opb = '0;
    mhi = '0; mlo = '0;
    #1;
    chk("rst_ctl", {busy, done, div_zero}, 0);
    chk("rst_hilo", {hi, lo}, 0);
    @(negedge clk); rst = 1'b0; @(negedge clk);
    run_op(3'd0, -32'sd3, 32'd5, 0);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'd3, 32'd100, 32'd7, 1);
    chk("divu", {hi, lo}, {32'd2, 32'd14});
    run_op(3'd2, -32'sd7, 32'd2, 0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(3'd4, 32'hAAAA_0000, 32'h0, 0);
    run_op(3'd5, 32'h5555, 32'h0, 0);
    run_op(3'd2, 32'd123, 32'h0, 0);
    chk("dz_keep", {hi, lo}, 64'hAAAA_0000_0000_5555);
    run_op(3'd5, 32'h1234, 32'h0, 1);
    chk("mtlo", lo, 32'h1234);
    run_op(3'd0, 32'd9, -32'sd4, 0);
    model(3'd0, 32'h12345, 32'h777);
    issue(3'd0, 32'h12345, 32'h777);
    repeat (5) @(negedge clk);
    start = 1'b1; oper = 3'd3; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        chk("busy_ign", {hi, lo}, {mhi, mlo});
      end
    end
    chk("one_done", nd, 1);
    issue(3'd3, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("cancel_nodone", nd, 0);
    chk("cancel_hilo", {hi, lo}, {mhi, mlo});
    cancel = 1'b1; start = 1'b1; oper = 3'd4; opa = 32'hDEAD_BEEF;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    chk("cancel_mthi", hi, mhi);
    run_op(3'd1, 32'hCAFE, 32'h1_0001, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_done", {hi, lo}, {mhi, mlo});
    for (int n = 0; n < 60; n++)
      run_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
    @(negedge clk);
    issue(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_hilo", {hi, lo}, 0);
    chk("rst_mid_busy", busy, 0);
    mhi = '0; mlo = '0;
    @(negedge clk); rst = 1'b0; @(negedge clk);
    run_op(3'd0, 32'd6, 32'd7, 0);
    chk("mult_6x7", lo, 32'd42);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
